audio_sample_streamer: RTL

//  Downstream consumer of the SRAM reading FSM. Issues sequential word reads over a
//  req/valid handshake and buffers 16-bit PCM samples in a small FIFO. On each codec

---
 rtl/audio_pkg.sv | 14 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/audio_sample_streamer.sv | 118 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types for the audio sample streamer: sample/address widths, FSM states
// and the saturating underrun increment.
package audio_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] sram_addr_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} stream_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with flush. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/audio_sample_streamer.sv
// Fetches clip words from the SRAM reader into a sample FIFO and hands one
// sample to the codec per sample strobe, with optional loop playback.
//
//  state | meaning
//  IDLE  | waiting for play and FIFO room
//  REQ   | rd_req asserted for one cycle at rd_addr
//  WAIT  | one read outstanding, waiting for rd_valid
//  FIN   | clip fully fetched (LOOP=0), done once FIFO drains
module audio_sample_streamer
  import audio_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter sram_addr_t START_ADDR = 20'h00000,
  parameter sram_addr_t END_ADDR   = 20'hFFFFF,
  parameter bit         LOOP       = 1'b1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              play,
  input  logic              restart,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] audio_out,
  output logic              audio_valid,
  output logic [15:0]       underrun_cnt,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH);

  stream_state_t state;
  logic          drop;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW:0]   fifo_count;
  sample_t       fifo_head;

  assign fifo_push = (state == WAIT) && rd_valid && !restart;
  assign fifo_pop  = sample_tick && play && !restart && !fifo_empty;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (Clk),
    .reset (reset),
    .flush (restart),
    .push  (fifo_push),
    .din   (rd_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_req       <= 1'b0;
      rd_addr      <= START_ADDR;
      audio_out    <= '0;
      audio_valid  <= 1'b0;
      underrun_cnt <= '0;
      done         <= 1'b0;
      drop         <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      if (restart) begin
        state   <= IDLE;
        rd_req  <= 1'b0;
        rd_addr <= START_ADDR;
        done    <= 1'b0;
        // A read latched by the reader but not yet returned must be swallowed
        drop    <= (state == REQ) || ((state == WAIT || drop) && !rd_valid);
      end else begin
        if (sample_tick) begin
          audio_valid <= 1'b1;
          if (play) begin
            if (!fifo_empty) begin
              audio_out <= fifo_head;
            end else begin
              audio_out    <= '0;
              underrun_cnt <= sat_inc16(underrun_cnt);
            end
          end
        end
        if (drop && rd_valid) drop <= 1'b0;
        case (state)
          IDLE: if (play && !done && !drop && !fifo_full) begin
            state  <= REQ;
            rd_req <= 1'b1;
          end
          REQ: begin
            state  <= WAIT;
            rd_req <= 1'b0;
          end
          WAIT: if (rd_valid) begin
            if (rd_addr == END_ADDR) begin
              if (LOOP) begin
                rd_addr <= START_ADDR;
                state   <= IDLE;
              end else begin
                state <= FIN;
              end
            end else begin
              rd_addr <= rd_addr + 1'b1;
              state   <= IDLE;
            end
          end
          FIN:     done  <= (fifo_count == '0);
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
